// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator display stage: segment patterns,
// decimal-digit segment lookup, converter FSM states and flag bit positions.
package calc_disp_pkg;

  // Segment order is {a,b,c,d,e,f,g}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  // Bit positions of the flags within the {Z,C,N,O} bus.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Active-low 7-segment pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). One bit is consumed per
// clock; a conversion takes exactly M cycles after start. done is high during
// the final step and bcd then carries the finished result, so a consumer can
// latch it on the same edge on which busy drops.
module bin_to_bcd_seq
  import calc_disp_pkg::*;
#(
  parameter int M    = 4,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [M-1:0]      bin,
  output logic              busy,
  output logic              done,
  output logic [NDIG*4-1:0] bcd
);

  localparam int BW = NDIG * 4;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [M-1:0]    r_bin;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_step;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_shifted;
  logic            w_last;

  // Add 3 to every digit that is 5 or more before the shift.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                             : r_bcd[gi*4 +: 4];
    end
  endgenerate

  assign w_shifted = {w_adj[BW-2:0], r_bin[M-1]};
  assign w_last    = (r_state == ST_CONV) && (r_step == CW'(M - 1));

  // Next-state logic: IDLE waits for start, CONV runs for M steps.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_CONV;
      ST_CONV: if (w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register plus the shift/accumulate datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin  <= bin;
            r_bcd  <= '0;
            r_step <= '0;
          end
        end
        ST_CONV: begin
          r_bin  <= {r_bin[M-2:0], 1'b0};
          r_bcd  <= w_shifted;
          r_step <= r_step + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == ST_CONV);
  assign done = w_last;
  assign bcd  = w_shifted;

endmodule

// File: rtl/calc_display_scan.sv
// Calculator display stage: latches an ALU result, converts it to BCD and
// scans it onto a multiplexed 7-segment display with a sign digit on top.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading decimal zeros.
module calc_display_scan
  import calc_disp_pkg::*;
#(
  parameter int M           = 4,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [M-1:0]      value,
  input  logic              sign,
  input  logic [3:0]        flags,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [3:0]        led
);

  localparam int NDIG = DIGITS - 1;
  localparam int BW   = NDIG * 4;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic              w_busy;
  logic              w_done;
  logic              w_start;
  logic [BW-1:0]     w_bcd;
  logic              r_sign_cap;
  logic [3:0]        r_flags_cap;
  logic [BW-1:0]     r_bcd_disp;
  logic              r_sign_disp;
  logic [3:0]        r_led;
  logic [CNTW-1:0]   r_cnt;
  logic [IW-1:0]     r_idx;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;
  logic              w_wrap;
  logic [DIGITS-1:0] w_an_sel;
  logic [6:0]        w_slot_seg [DIGITS];

  // A load is only honoured while the converter is idle.
  assign w_start = load && !w_busy;

  bin_to_bcd_seq #(
    .M    (M),
    .NDIG (NDIG)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (value),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Capture sign/flags at load; publish digits, sign and LEDs together at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign_cap  <= 1'b0;
      r_flags_cap <= '0;
      r_bcd_disp  <= '0;
      r_sign_disp <= 1'b0;
      r_led       <= '0;
    end else begin
      if (w_start) begin
        r_sign_cap  <= sign;
        r_flags_cap <= flags;
      end
      if (w_done) begin
        r_bcd_disp  <= w_bcd;
        r_sign_disp <= r_sign_cap;
        r_led       <= {r_flags_cap[FLAG_Z], r_flags_cap[FLAG_C],
                        r_flags_cap[FLAG_N], r_flags_cap[FLAG_O]};
      end
    end
  end

  // Segment pattern for every slot; decimal digits below, sign digit on top.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_slot
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_units
        assign w_slot_seg[gi] = seg7(r_bcd_disp[3:0]);
      end else begin : g_upper
        // Blank when this digit and all above it are zero.
        assign w_slot_seg[gi] = (|r_bcd_disp[BW-1:gi*4]) ? seg7(r_bcd_disp[gi*4 +: 4])
                                                         : SEG_BLANK;
      end
`else
      assign w_slot_seg[gi] = seg7(r_bcd_disp[gi*4 +: 4]);
`endif
    end
  endgenerate

  assign w_slot_seg[NDIG] = r_sign_disp ? SEG_MINUS : SEG_BLANK;

  assign w_wrap   = (r_cnt == CNTW'(REFRESH_DIV - 1));
  assign w_an_sel = ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);

  // Refresh counter and scan index; an/seg are registered together on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_an  <= w_an_sel;
      r_seg <= w_slot_seg[r_idx];
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

`ifndef SYNTHESIS
  // Digits published to the display must always be decimal.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_chk
      always_ff @(posedge clk) begin
        if (!rst) assert (r_bcd_disp[gi*4 +: 4] <= 4'd9);
      end
    end
  endgenerate
`endif

  assign busy = w_busy;
  assign seg  = r_seg;
  assign an   = r_an;
  assign led  = r_led;

endmodule

// File: tb/tb_calc_display_scan.sv
// Directed bench for calc_display_scan: an M=4 and an M=8 instance, both with
// DIGITS=4 and REFRESH_DIV=4, checked against hand-computed segment patterns.
module tb_calc_display_scan;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       load4, sign4, busy4;
  logic [3:0] value4, flags4, an4, led4;
  logic [6:0] seg4;
  logic       load8, sign8, busy8;
  logic [7:0] value8;
  logic [3:0] flags8, an8, led8;
  logic [6:0] seg8;

  int n_checks = 0;
  int n_fail   = 0;

  calc_display_scan #(.M(4), .DIGITS(4), .REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .load(load4), .value(value4), .sign(sign4), .flags(flags4),
    .busy(busy4), .seg(seg4), .an(an4), .led(led4)
  );

  calc_display_scan #(.M(8), .DIGITS(4), .REFRESH_DIV(4)) dut8 (
    .clk(clk), .rst(rst), .load(load8), .value(value8), .sign(sign8), .flags(flags8),
    .busy(busy8), .seg(seg8), .an(an8), .led(led8)
  );

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_MINUS = 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] S_LZ = 7'b1111111;
`else
  localparam logic [6:0] S_LZ = 7'b0000001;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input bit sel);
    return sel ? an8 : an4;
  endfunction

  // One-cycle load strobe driven at a falling edge; returns at the next falling edge.
  task automatic pulse_load(input bit sel, input logic [7:0] v, input logic s, input logic [3:0] f);
    @(negedge clk);
    $display("load dut%0d value=%0d sign=%0b flags=%04b", sel ? 8 : 4, v, s, f);
    if (sel) begin
      load8 = 1'b1; value8 = v; sign8 = s; flags8 = f;
    end else begin
      load4 = 1'b1; value4 = v[3:0]; sign4 = s; flags4 = f;
    end
    @(negedge clk);
    load4 = 1'b0;
    load8 = 1'b0;
  endtask

  // Counts falling edges at which busy is still high (bounded).
  task automatic busy_cycles(input bit sel, output int n);
    n = 0;
    while ((sel ? busy8 : busy4) && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Waits for a fresh scan slot selecting 'target' and returns its segments.
  task automatic get_slot(input bit sel, input logic [3:0] target, output logic [6:0] s);
    int k;
    k = 0;
    while (an_of(sel) == target && k < 64) begin k++; @(negedge clk); end
    k = 0;
    while (an_of(sel) != target && k < 64) begin k++; @(negedge clk); end
    if (an_of(sel) != target) check("slot_wait", {28'd0, an_of(sel)}, {28'd0, target});
    s = sel ? seg8 : seg4;
    $display("slot dut%0d an=%04b seg=%07b", sel ? 8 : 4, target, s);
  endtask

  initial begin
    logic [6:0] s;
    int         n;

    rst = 1'b1;
    load4 = 1'b0; value4 = '0; sign4 = 1'b0; flags4 = '0;
    load8 = 1'b0; value8 = '0; sign8 = 1'b0; flags8 = '0;

    // 1: reset state and first scan slot
    repeat (2) @(negedge clk);
    check("rst_seg",  seg4,  S_BLANK);
    check("rst_an",   an4,   4'b1111);
    check("rst_led",  led4,  4'b0000);
    check("rst_busy", busy4, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_wrap_an", an4, 4'b1111);
    @(negedge clk);
    check("first_an",  an4,  4'b1110);
    check("first_seg", seg4, 7'b0000001);

    // 2: value 9, positive
    pulse_load(1'b0, 8'd9, 1'b0, 4'b0100);
    busy_cycles(1'b0, n);
    check("t2_busy_len", n, 4);
    check("t2_led", led4, 4'b0100);
    get_slot(1'b0, 4'b1110, s); check("t2_d0",   s, 7'b0000100);
    get_slot(1'b0, 4'b1101, s); check("t2_d1",   s, S_LZ);
    get_slot(1'b0, 4'b0111, s); check("t2_sign", s, S_BLANK);

    // 3: value 3, negative
    pulse_load(1'b0, 8'd3, 1'b1, 4'b0010);
    busy_cycles(1'b0, n);
    check("t3_busy_len", n, 4);
    get_slot(1'b0, 4'b0111, s); check("t3_sign", s, S_MINUS);
    get_slot(1'b0, 4'b1110, s); check("t3_d0",   s, 7'b0000110);
    check("t3_led", led4, 4'b0010);

    // 4: 8-bit instance, value 205 then 7
    pulse_load(1'b1, 8'd205, 1'b0, 4'b1000);
    busy_cycles(1'b1, n);
    check("t4_busy_len", n, 8);
    get_slot(1'b1, 4'b1110, s); check("t4_205_d0", s, 7'b0100100);
    get_slot(1'b1, 4'b1101, s); check("t4_205_d1", s, 7'b0000001);
    get_slot(1'b1, 4'b1011, s); check("t4_205_d2", s, 7'b0010010);
    get_slot(1'b1, 4'b0111, s); check("t4_205_sg", s, S_BLANK);
    check("t4_led", led8, 4'b1000);
    pulse_load(1'b1, 8'd7, 1'b0, 4'b0000);
    busy_cycles(1'b1, n);
    get_slot(1'b1, 4'b1101, s); check("t4_7_d1", s, S_LZ);
    get_slot(1'b1, 4'b1011, s); check("t4_7_d2", s, S_LZ);
    get_slot(1'b1, 4'b1110, s); check("t4_7_d0", s, 7'b0001111);

    // 5: second load while busy is dropped
    @(negedge clk);
    $display("load dut4 value=5 then value=2 while busy");
    load4 = 1'b1; value4 = 4'd5; sign4 = 1'b0; flags4 = 4'b0001;
    @(negedge clk);
    load4 = 1'b1; value4 = 4'd2; flags4 = 4'b1111;
    @(negedge clk);
    load4 = 1'b0;
    busy_cycles(1'b0, n);
    check("t5_busy_len", n + 1, 4);
    get_slot(1'b0, 4'b1110, s); check("t5_d0", s, 7'b0100100);
    check("t5_led", led4, 4'b0001);

    // 6: reset in the middle of a conversion
    pulse_load(1'b0, 8'd7, 1'b1, 4'b1111);
    @(negedge clk);
    rst = 1'b1;
    $display("reset during conversion");
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", busy4, 1'b0);
    check("t6_led",  led4,  4'b0000);
    check("t6_an",   an4,   4'b1111);
    get_slot(1'b0, 4'b1110, s); check("t6_d0",   s, 7'b0000001);
    get_slot(1'b0, 4'b0111, s); check("t6_sign", s, S_BLANK);
    pulse_load(1'b0, 8'd1, 1'b0, 4'b0000);
    busy_cycles(1'b0, n);
    get_slot(1'b0, 4'b1110, s); check("t6_one", s, 7'b1001111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
